// File: rtl/mem_access_unit.sv
// Load/store unit: maps byte/half/word/dword accesses onto lane-aligned memory bus beats.
// Define MISALIGN_SPLIT_EN to serve misaligned accesses (two beats when crossing a lane word).
module mem_access_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_sign,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_byteen,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);
  localparam int unsigned N     = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(N);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                we_q, sign_q, err_q;
  logic [DATA_W-1:0]   wdata_q, rdata0_q;
  logic [2*DATA_W-1:0] rd_cat;
  logic [DATA_W-1:0]   rd_shift;
  logic [ADDR_W-1:0]   lane_addr;
  logic [OFF_W-1:0]    off_q;
  logic                accept, size_err, req_err, ext;
  int unsigned         off_n, bytes_n;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign size_err  = 32'(req_size) > OFF_W;
  assign off_q     = addr_q[OFF_W-1:0];
  assign off_n     = 32'(off_q);
  assign bytes_n   = 32'd1 << size_q;
  assign lane_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef MISALIGN_SPLIT_EN
  logic [DATA_W-1:0] rdata1_q;
  logic              split;
  assign split   = (off_n + bytes_n) > N;
  assign req_err = size_err;
  assign rd_cat  = {rdata1_q, rdata0_q};
`else
  logic [OFF_W-1:0] align_mask;
  assign align_mask = OFF_W'((32'd1 << req_size) - 32'd1);
  assign req_err    = size_err || (|(req_addr[OFF_W-1:0] & align_mask));
  assign rd_cat     = {{DATA_W{1'b0}}, rdata0_q};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = req_err ? StResp : StBeat0;
`ifdef MISALIGN_SPLIT_EN
      StBeat0: if (bus_ready) state_d = split ? StBeat1 : StResp;
      StBeat1: if (bus_ready) state_d = StResp;
`else
      StBeat0: if (bus_ready) state_d = StResp;
`endif
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata0_q <= '0;
`ifdef MISALIGN_SPLIT_EN
      rdata1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        we_q    <= req_we;
        sign_q  <= req_sign;
        err_q   <= req_err;
        wdata_q <= req_wdata;
      end
      if (state_q == StBeat0 && bus_ready) rdata0_q <= bus_rdata;
`ifdef MISALIGN_SPLIT_EN
      if (state_q == StBeat1 && bus_ready) rdata1_q <= bus_rdata;
`endif
    end
  end

  // Bus outputs are decoded from registered state only, so they hold steady through stalls.
  always_comb begin
    bus_valid  = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_byteen = '0;
    bus_wdata  = '0;
    if (state_q == StBeat0) begin
      bus_valid = 1'b1;
      bus_we    = we_q;
      bus_addr  = lane_addr;
      bus_wdata = wdata_q << (8 * off_n);
      for (int unsigned i = 0; i < N; i++) begin
        bus_byteen[i] = we_q && (i >= off_n) && (i < off_n + bytes_n);
      end
    end
`ifdef MISALIGN_SPLIT_EN
    else if (state_q == StBeat1) begin
      bus_valid = 1'b1;
      bus_we    = we_q;
      bus_addr  = lane_addr + ADDR_W'(N);
      bus_wdata = wdata_q >> (8 * (N - off_n));
      for (int unsigned i = 0; i < N; i++) begin
        bus_byteen[i] = we_q && (i + N < off_n + bytes_n);
      end
    end
`endif
  end

  always_comb begin
    rsp_valid = (state_q == StResp);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = '0;
    rd_shift  = DATA_W'(rd_cat >> (8 * off_n));
    ext       = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i + 1 == bytes_n) ext = sign_q && rd_shift[8*i+7];
    end
    if (rsp_valid && !we_q && !err_q) begin
      for (int unsigned i = 0; i < N; i++) begin
        rsp_rdata[8*i +: 8] = (i < bytes_n) ? rd_shift[8*i +: 8] : {8{ext}};
      end
    end
  end

endmodule
